// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction prefetch queue with redirect flush
// Optional HLT-opcode fetch stop: define PREFETCH_HALT_DETECT_EN.
module instr_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 8,
   parameter int          INSTR_W  = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [ADDR_W-1:0]        imem_addr,
   output logic                     imem_req,
   input  logic [INSTR_W-1:0]       imem_data,
   output logic                     deq_valid,
   output logic [INSTR_W-1:0]       deq_instr,
   output logic [ADDR_W-1:0]        deq_pc,
   input  logic                     deq_ready,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic               inflight_q, inflight_d;
   logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
   logic               halted_q, halted_d;

   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];

   logic [CNT_W-1:0]   occupancy;
   logic               issue;
   logic               enq;
   logic               deq;
   logic               halt_hit;

   // Slots are reserved at issue time, so a returning response never finds the queue full.
   always_comb begin
      occupancy = count_q + CNT_W'(inflight_q);
      issue     = rst && !redirect && !halted_q && (occupancy < CNT_W'(DEPTH));
      enq       = inflight_q && !redirect;
      deq       = (count_q != '0) && deq_ready && !redirect;
`ifdef PREFETCH_HALT_DETECT_EN
      halt_hit  = enq && (imem_data[INSTR_W-1 -: 4] == 4'hF);
`else
      halt_hit  = 1'b0;
`endif
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      halted_d      = halted_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         inflight_d = 1'b0;
         halted_d   = 1'b0;
      end else begin
         if (issue) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            inflight_pc_d = fetch_pc_q;
         end
         if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
         end else if (!enq && deq) begin
            count_d = count_q - CNT_W'(1);
         end
         if (halt_hit) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q    <= ADDR_W'(RESET_PC);
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= ADDR_W'(RESET_PC);
         halted_q      <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         halted_q      <= halted_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && enq) begin
         pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_data;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign imem_req  = issue;
   assign deq_valid = (count_q != '0);
   assign deq_pc    = pc_mem_q[rd_ptr_q];
   assign deq_instr = instr_mem_q[rd_ptr_q];
   assign count     = count_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  imem_addr;
   logic        imem_req;
   logic [15:0] imem_data;
   logic        deq_valid;
   logic [15:0] deq_instr;
   logic [7:0]  deq_pc;
   logic        deq_ready;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] mem [256];

   instr_prefetch_queue #(.DEPTH(4), .ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_data(imem_data), .deq_valid(deq_valid), .deq_instr(deq_instr),
      .deq_pc(deq_pc), .deq_ready(deq_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .count(count)
   );

   always #5 clk = ~clk;

   initial imem_data = 16'h0;
   always @(posedge clk) if (imem_req) imem_data <= mem[imem_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: queued (pc,instr) pairs, one optional outstanding fetch.
   logic [7:0]  mq_pc [$];
   logic [15:0] mq_instr [$];
   bit          m_live = 0;
   bit          m_infl;
   logic [7:0]  m_ipc;
   logic [15:0] m_iinstr;
   logic [7:0]  m_fpc;
   bit          m_halted;
   bit          exp_req;

   always @(negedge clk) begin
      exp_req = rst && !redirect && !m_halted && ((mq_pc.size() + int'(m_infl)) < 4);
      if (m_live) begin
         chk("m_imem_req", imem_req, exp_req);
         chk("m_imem_addr", imem_addr, m_fpc);
         chk("m_count", count, mq_pc.size());
         chk("m_deq_valid", deq_valid, mq_pc.size() != 0);
         chk("m_no_overflow", count <= 3'd4, 1);
         if (mq_pc.size() != 0) begin
            chk("m_deq_pc", deq_pc, mq_pc[0]);
            chk("m_deq_instr", deq_instr, mq_instr[0]);
         end
      end
      if (!rst) begin
         mq_pc.delete(); mq_instr.delete();
         m_infl = 0; m_fpc = 8'h00; m_halted = 0; m_live = 1;
      end else if (m_live) begin
         if (redirect) begin
            mq_pc.delete(); mq_instr.delete();
            m_infl = 0; m_fpc = redirect_pc; m_halted = 0;
         end else begin
            if (mq_pc.size() != 0 && deq_ready) begin
               void'(mq_pc.pop_front()); void'(mq_instr.pop_front());
            end
            if (m_infl) begin
               mq_pc.push_back(m_ipc); mq_instr.push_back(m_iinstr);
`ifdef PREFETCH_HALT_DETECT_EN
               if (m_iinstr[15:12] == 4'hF) m_halted = 1;
`endif
            end
            if (exp_req) begin
               m_infl = 1; m_ipc = m_fpc; m_iinstr = mem[m_fpc]; m_fpc = m_fpc + 8'd1;
            end else begin
               m_infl = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; deq_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      repeat (3) step();
   endtask

   // Ends at a negedge with deq_valid high, or reports a timeout.
   task automatic wait_valid(input string nm);
      bit seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (deq_valid) begin seen = 1; break; end
         step();
      end
      if (!seen) chk(nm, 0, 1);
   endtask

   logic [7:0] exp_pcs [4];
   logic [7:0] got [$];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      do_reset();
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_deq_valid", deq_valid, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 8'h00);

      // Streaming from reset: first valid on the third cycle, then one per cycle.
      step(); rst = 1'b1; deq_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 2) chk("t1_latency_low", deq_valid, 0);
         else begin
            chk("t1_valid", deq_valid, 1);
            chk("t1_pc", deq_pc, 8'(c - 2));
            chk("t1_instr", deq_instr, 16'h1000 + 16'(c - 2));
         end
         step();
      end

      // Back-pressure fills the queue, then drains in order and resumes at PC 4.
      do_reset();
      rst = 1'b1; deq_ready = 1'b0;
      repeat (8) step();
      @(negedge clk);
      chk("t2_count_full", count, 4);
      chk("t2_req_stalled", imem_req, 0);
      chk("t2_addr", imem_addr, 8'h04);
      chk("t2_head_pc", deq_pc, 8'h00);
      step(); deq_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t2_drain_valid", deq_valid, 1);
         chk("t2_drain_pc", deq_pc, 8'(i));
         step();
      end

      // Redirect with three queued entries and one fetch outstanding.
      do_reset();
      rst = 1'b1; deq_ready = 1'b0;
      begin
         bit hit = 0;
         for (int k = 0; k < 20; k++) begin
            if (count == 3'd3) begin hit = 1; break; end
            step();
         end
         if (!hit) chk("t3_reach_count3", 0, 1);
      end
      redirect = 1'b1; redirect_pc = 8'h40;
      @(negedge clk);
      chk("t3_req_during_redirect", imem_req, 0);
      step(); redirect = 1'b0; deq_ready = 1'b1;
      @(negedge clk);
      chk("t3_count_flushed", count, 0);
      chk("t3_valid_flushed", deq_valid, 0);
      wait_valid("t3_timeout");
      chk("t3_first_pc", deq_pc, 8'h40);
      step(); @(negedge clk);
      chk("t3_second_pc", deq_pc, 8'h41);

      // Address wrap FE -> FF -> 00 -> 01.
      step(); redirect = 1'b1; redirect_pc = 8'hFE;
      step(); redirect = 1'b0;
      exp_pcs[0] = 8'hFE; exp_pcs[1] = 8'hFF; exp_pcs[2] = 8'h00; exp_pcs[3] = 8'h01;
      wait_valid("t4_timeout");
      for (int i = 0; i < 4; i++) begin
         chk("t4_wrap_pc", deq_pc, exp_pcs[i]);
         step(); @(negedge clk);
      end

      // Redirect coinciding with a dequeue handshake.
      step();
      redirect = 1'b1; redirect_pc = 8'h20;
      @(negedge clk);
      chk("t5_handshake_valid", deq_valid, 1);
      step(); redirect = 1'b0;
      @(negedge clk);
      chk("t5_count_zero", count, 0);
      chk("t5_valid_zero", deq_valid, 0);
      wait_valid("t5_timeout");
      chk("t5_first_pc", deq_pc, 8'h20);

      // HLT opcode at address 2.
      do_reset();
      mem[2] = 16'hF000;
      rst = 1'b1; deq_ready = 1'b1;
      got.delete();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (deq_valid) got.push_back(deq_pc);
         step();
      end
      @(negedge clk);
      chk("t6_pc2_seen", got.size() > 2 ? got[2] : 8'hxx, 8'h02);
`ifdef PREFETCH_HALT_DETECT_EN
      chk("t6_halt_count", got.size(), 4);
      chk("t6_halt_req", imem_req, 0);
`else
      chk("t6_past_hlt", got.size() > 4 ? got[4] : 8'hxx, 8'h04);
`endif
      step(); redirect = 1'b1; redirect_pc = 8'h10;
      step(); redirect = 1'b0;
      wait_valid("t6_timeout");
      chk("t6_resume_pc", deq_pc, 8'h10);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Instruction prefetch buffer between the 8-bit-addressed, 16-bit-wide instruction memory and the processor's fetch/decode front end. It runs ahead of the pipeline, keeps up to DEPTH fetched instructions with their PCs, and hands them downstream over a valid/ready handshake. Taken branches and jumps from the execute stage raise a redirect, which flushes the queue and restarts fetch at the new PC.

Parameters:
DEPTH, 4, queue entries; power of two, >=2.
ADDR_W, 8, instruction address width.
INSTR_W, 16, instruction width.
RESET_PC, 0, first fetch address after reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
imem_addr  output  ADDR_W  instruction memory address.
imem_req  output  1  a fetch is issued this cycle at imem_addr.
imem_data  input  INSTR_W  memory read data; valid the cycle after the matching imem_req.
deq_valid  output  1  head entry is valid.
deq_instr  output  INSTR_W  head instruction.
deq_pc  output  ADDR_W  PC of the head instruction.
deq_ready  input  1  consumer accepts the head this cycle.
redirect  input  1  flush the queue and restart fetch.
redirect_pc  input  ADDR_W  new fetch PC; used when redirect=1.
count  output  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst=0 at an edge): fetch_pc<=RESET_PC, count<=0, rd/wr pointers<=0, inflight<=0. Outputs: imem_req=0, imem_addr=RESET_PC, deq_valid=0, count=0. Reset mid-fetch discards any in-flight response.
- imem_addr is driven directly from fetch_pc.
- Issue rule: imem_req = (count + inflight < DEPTH) && !redirect && !halted. inflight is the registered value of imem_req. This rule means a response always has a free slot.
- On an issue edge: fetch_pc <= fetch_pc+1, wrapping 8'hFF -> 8'h00. The issued address is held in inflight_pc.
- Response: when inflight=1 and no redirect is active this cycle, {imem_data, inflight_pc} is written at wr_ptr on the next edge.
- Dequeue: deq_valid = (count != 0). deq_instr and deq_pc come from the rd_ptr entry, combinationally. Handshake when deq_valid && deq_ready; rd_ptr advances.
- Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- deq_ready with deq_valid=0 has no effect. Overflow and underflow are impossible by construction; a bench assertion checks this.
- Redirect has priority over everything else in its cycle:
  - Queue is cleared (count<=0, pointers<=0).
  - Any in-flight response is discarded; inflight<=0.
  - A dequeue in that cycle is not counted.
  - imem_req=0 in that cycle.
  - fetch_pc<=redirect_pc.
  - The first new request is issued the next cycle.
- Latency: from reset release or redirect, first instruction appears at deq_valid=1 three cycles later (request, data, enqueue).
- Throughput: one instruction per cycle with deq_ready held high.
- Consecutive redirects: the last one wins. No requests are issued while redirect is held.

Optional Feature:
Macro PREFETCH_HALT_DETECT_EN.
- Defined: when an enqueued instruction has [15:12]==4'hF (HLT), a halted flag is set and no further imem_req is issued. A response already in flight is still enqueued. Entries already queued drain normally. halted clears on redirect or reset.
- Undefined: no opcode inspection; fetch continues sequentially regardless of contents.

Test Plan:
- Reset, then release with a memory holding mem[i]=16'h1000+i and deq_ready=1 -> deq_valid first high 3 cycles after release; deq_pc 0,1,2,... with deq_instr 16'h1000,16'h1001,... on consecutive cycles.
- deq_ready=0 after release -> count saturates at 4 (PCs 0..3) and imem_req stays 0; raise deq_ready -> entries drain in order, then streaming resumes at PC 4.
- Streaming, then redirect=1 with redirect_pc=8'h40 while count=3 and a request is in flight -> next cycle count=0, deq_valid=0; then deq_pc=8'h40 with no stale PC emitted.
- Start with redirect_pc=8'hFE and stream -> deq_pc sequence FE, FF, 00, 01.
- Redirect in the same cycle as deq_valid && deq_ready -> entry not double-consumed; count=0 next cycle.
- With PREFETCH_HALT_DETECT_EN defined and mem[2]=16'hF000 -> PCs 0,1,2 delivered, at most one further in-flight entry, then imem_req stays 0. Redirect to 8'h10 resumes fetch. Without the macro, fetch continues past 2.
